// File: rtl/mi_bram_target.sv
// Block-RAM responder for the internal memory interface: accepts one burst at a
// time and streams write acks or read strobes, optionally spaced by GAP idle cycles.
module mi_bram_target #(
  parameter int ADDR_WIDTH = 32,
  parameter int AW         = 8,
  parameter int GAP        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mi_addr,
  input  logic [6:0]            mi_len,
  input  logic                  mi_rw,
  input  logic                  mi_valid,
  output logic                  mi_ready,
  input  logic [31:0]           mi_wdata,
  output logic                  mi_wack,
  output logic                  mi_wlast,
  output logic [31:0]           mi_rdata,
  output logic                  mi_rstb,
  output logic                  mi_rlast,
  output logic [1:0]            fsm_state
);

  // Handshake: a request transfers on a rising edge where mi_valid & mi_ready;
  // mi_wack/mi_rstb are single-cycle pulses with no back-pressure.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic [15:0] GAP_N = 16'(GAP);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [6:0]    len_q;
  logic [6:0]    beat_q;
  logic [15:0]   gap_q;
  logic          issue_q;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          last_beat;
  logic          unused_addr;

  assign last_beat   = (beat_q == len_q);
  assign fsm_state   = state;
  assign unused_addr = ^mi_addr[ADDR_WIDTH-1:AW];

  // Plain write port, no reset, so contents survive rst_n and map onto BRAM.
  always_ff @(posedge clk) begin
    if (state == WRITE && mi_wack)
      mem[addr_q] <= mi_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mi_ready <= 1'b0;
      mi_wack  <= 1'b0;
      mi_wlast <= 1'b0;
      mi_rstb  <= 1'b0;
      mi_rlast <= 1'b0;
      mi_rdata <= 32'h0;
      addr_q   <= '0;
      len_q    <= 7'd0;
      beat_q   <= 7'd0;
      gap_q    <= 16'd0;
      issue_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mi_ready <= 1'b1;
          if (mi_valid && mi_ready) begin
            mi_ready <= 1'b0;
            addr_q   <= mi_addr[AW-1:0];
            len_q    <= mi_len;
            beat_q   <= 7'd0;
            gap_q    <= 16'd0;
            if (mi_rw) begin
              state   <= READ;
              issue_q <= 1'b1;
            end else begin
              state    <= WRITE;
              mi_wack  <= 1'b1;
              mi_wlast <= (mi_len == 7'd0);
            end
          end
        end

        WRITE: begin
          if (mi_wack) begin
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 7'd1;
            if (last_beat) begin
              mi_wack  <= 1'b0;
              mi_wlast <= 1'b0;
              mi_ready <= 1'b1;
              state    <= IDLE;
            end else if (GAP_N == 16'd0) begin
              mi_wlast <= (beat_q + 7'd1 == len_q);
            end else begin
              mi_wack <= 1'b0;
              gap_q   <= GAP_N;
            end
          end else if (gap_q > 16'd1) begin
            gap_q <= gap_q - 16'd1;
          end else begin
            // beat_q already points at the next beat here
            gap_q    <= 16'd0;
            mi_wack  <= 1'b1;
            mi_wlast <= last_beat;
          end
        end

        READ: begin
          mi_rstb  <= 1'b0;
          mi_rlast <= 1'b0;
          if (issue_q) begin
            mi_rdata <= mem[addr_q];
            mi_rstb  <= 1'b1;
            mi_rlast <= last_beat;
            addr_q   <= addr_q + 1'b1;
            beat_q   <= beat_q + 7'd1;
            if (last_beat) begin
              issue_q <= 1'b0;
            end else if (GAP_N != 16'd0) begin
              issue_q <= 1'b0;
              gap_q   <= GAP_N;
            end
          end else if (mi_rlast) begin
            // final strobe is on the bus this cycle
            state    <= IDLE;
            mi_ready <= 1'b1;
          end else if (gap_q > 16'd1) begin
            gap_q <= gap_q - 16'd1;
          end else if (gap_q == 16'd1) begin
            gap_q   <= 16'd0;
            issue_q <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          mi_ready <= 1'b0;
          mi_wack  <= 1'b0;
          mi_wlast <= 1'b0;
          mi_rstb  <= 1'b0;
          mi_rlast <= 1'b0;
          issue_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mi_bram_target.sv
// Scoreboard bench for mi_bram_target: one back-to-back instance and one GAP=2
// instance share the request bus; a negedge monitor checks every strobe.
module tb_mi_bram_target;

  localparam int EW = 66; // {is_read, last, cycle[31:0], data[31:0]}

  logic        clk;
  logic        rst_n;
  logic [31:0] mi_addr;
  logic [6:0]  mi_len;
  logic        mi_rw;
  logic        mi_valid;
  logic [31:0] mi_wdata;
  logic        sel;

  logic        ready0, wack0, wlast0, rstb0, rlast0;
  logic        ready1, wack1, wlast1, rstb1, rlast1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  state0, state1;
  logic        valid0, valid1;

  logic        ready_s, wack_s, wlast_s, rstb_s, rlast_s;
  logic [31:0] rdata_s;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   wdat_q[$];
  logic [31:0]   vec [128];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  assign valid0  = mi_valid & ~sel;
  assign valid1  = mi_valid & sel;
  assign ready_s = sel ? ready1 : ready0;
  assign wack_s  = sel ? wack1  : wack0;
  assign wlast_s = sel ? wlast1 : wlast0;
  assign rstb_s  = sel ? rstb1  : rstb0;
  assign rlast_s = sel ? rlast1 : rlast0;
  assign rdata_s = sel ? rdata1 : rdata0;

  mi_bram_target #(.ADDR_WIDTH(32), .AW(8), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
    .mi_valid(valid0), .mi_ready(ready0), .mi_wdata(mi_wdata), .mi_wack(wack0),
    .mi_wlast(wlast0), .mi_rdata(rdata0), .mi_rstb(rstb0), .mi_rlast(rlast0),
    .fsm_state(state0)
  );

  mi_bram_target #(.ADDR_WIDTH(32), .AW(8), .GAP(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
    .mi_valid(valid1), .mi_ready(ready1), .mi_wdata(mi_wdata), .mi_wack(wack1),
    .mi_wlast(wlast1), .mi_rdata(rdata1), .mi_rstb(rstb1), .mi_rlast(rlast1),
    .fsm_state(state1)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per strobe and feeds write data on wack
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    if (wack_s || rstb_s) begin
      chk("strobe_overlap", {31'h0, wack_s & rstb_s}, 32'h0);
      chk("ready_low_in_burst", {31'h0, ready_s}, 32'h0);
      got = {rstb_s, (rstb_s ? rlast_s : wlast_s), 32'(cyc), (rstb_s ? rdata_s : 32'h0)};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat: got rd=%b last=%b cyc=%0d data=%h expected rd=%b last=%b cyc=%0d data=%h",
                   got[65], got[64], got[63:32], got[31:0], e[65], e[64], e[63:32], e[31:0]);
        end
      end
    end
    if (wack_s) begin
      if (wdat_q.size() > 0) mi_wdata = wdat_q.pop_front();
      else mi_wdata = 32'hDEAD_BEEF;
    end
  end

  // driver: issue one burst (data from vec), push expectations, wait for ready
  task automatic burst(input logic s, input logic rw, input logic [31:0] addr,
                       input int len, input logic hold);
    int g, t, lc, k, n, first;
    g = s ? 2 : 0;
    n = len + 1;
    first = rw ? 2 : 1;
    sel = s;
    mi_rw = rw;
    mi_addr = addr;
    mi_len = len[6:0];
    mi_valid = 1'b1;
    k = 0;
    while (!ready_s && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!ready_s) begin
      chk("accept_timeout", 32'h0, 32'h1);
      mi_valid = 1'b0;
      return;
    end
    if (!rw) for (int i = 0; i < n; i++) wdat_q.push_back(vec[i]);
    t = cyc;
    for (int i = 0; i < n; i++)
      exp_q.push_back({rw, (i == n - 1), 32'(t + first + i * (g + 1)), (rw ? vec[i] : 32'h0)});
    lc = t + first + (n - 1) * (g + 1);
    @(negedge clk);
    if (!hold) mi_valid = 1'b0;
    while (cyc < lc + 1) @(negedge clk);
    chk("ready_after_burst", {31'h0, ready_s}, 32'h1);
    chk("all_beats_seen", exp_q.size(), 32'h0);
    exp_q.delete();
    wdat_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {31'h0, ready0}, 32'h0);
    chk("rst_wack", {31'h0, wack0}, 32'h0);
    chk("rst_wlast", {31'h0, wlast0}, 32'h0);
    chk("rst_rstb", {31'h0, rstb0}, 32'h0);
    chk("rst_rlast", {31'h0, rlast0}, 32'h0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_state", {30'h0, state0}, 32'h0);
    chk("rst_ready_gap", {31'h0, ready1}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; mi_valid = 1'b0; mi_addr = 32'h0; mi_len = 7'd0;
    mi_rw = 1'b0; mi_wdata = 32'h0; sel = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", {31'h0, ready0}, 32'h0);
    @(posedge clk); #1;
    chk("ready_first_edge", {31'h0, ready0}, 32'h1);
    @(negedge clk);

    // basic write / read-back
    vec[0] = 32'hA0; vec[1] = 32'hA1; vec[2] = 32'hA2; vec[3] = 32'hA3;
    burst(0, 0, 32'h10, 3, 0);
    burst(0, 1, 32'h10, 3, 0);

    // wrap-around and upper-address aliasing
    vec[0] = 32'h1; vec[1] = 32'h2; vec[2] = 32'h3; vec[3] = 32'h4;
    burst(0, 0, 32'hFE, 3, 0);
    vec[0] = 32'h3; vec[1] = 32'h4;
    burst(0, 1, 32'h00, 1, 0);
    vec[0] = 32'h1; vec[1] = 32'h2;
    burst(0, 1, 32'h1FE, 1, 0);

    // single-beat bursts
    vec[0] = 32'h55;
    burst(0, 0, 32'h20, 0, 0);
    burst(0, 1, 32'h20, 0, 0);

    // maximum length burst
    for (int i = 0; i < 128; i++) vec[i] = 32'h1000 + i;
    burst(0, 0, 32'h80, 127, 0);
    burst(0, 1, 32'h80, 127, 0);

    // gapped instance
    vec[0] = 32'hD0; vec[1] = 32'hD1; vec[2] = 32'hD2;
    burst(1, 0, 32'h30, 2, 0);
    burst(1, 1, 32'h30, 2, 0);
    sel = 1'b0;

    // valid held high with alternating direction
    vec[0] = 32'hE0; vec[1] = 32'hE1;
    burst(0, 0, 32'h50, 1, 1);
    burst(0, 1, 32'h50, 1, 1);
    vec[0] = 32'hE2;
    burst(0, 0, 32'h52, 0, 1);
    vec[0] = 32'hE0; vec[1] = 32'hE1; vec[2] = 32'hE2;
    burst(0, 1, 32'h50, 2, 0);

    // reset during an 8-beat write
    for (int i = 0; i < 8; i++) vec[i] = 32'hB0 + i;
    burst(0, 0, 32'h40, 7, 0);
    mi_rw = 1'b0; mi_addr = 32'h40; mi_len = 7'd7; mi_valid = 1'b1;
    wdat_q.push_back(32'hC0);
    wdat_q.push_back(32'hC1);
    exp_q.push_back({1'b0, 1'b0, 32'(cyc + 1), 32'h0});
    exp_q.push_back({1'b0, 1'b0, 32'(cyc + 2), 32'h0});
    @(posedge clk); #1 mi_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    chk("abort_beats_seen", exp_q.size(), 32'h0);
    exp_q.delete();
    wdat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_abort", {31'h0, ready0}, 32'h1);
    @(negedge clk);
    vec[0] = 32'hC0; vec[1] = 32'hC1;
    for (int i = 2; i < 8; i++) vec[i] = 32'hB0 + i;
    burst(0, 1, 32'h40, 7, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mi_bram_target.md
Name: mi_bram_target

Overview:
- Responder (target) for the internal memory interface (mi_*), backed by on-chip block RAM.
- Accepts burst read/write requests from an mi initiator such as the memory tester, with the same request/data handshakes as the QPI memory controller.
- Used as a drop-in substitute for the PSRAM path, so initiators can be brought up and regression-tested without the external RAM.
- An optional inter-beat gap emulates a slower memory.

Parameters:
- ADDR_WIDTH, 32, width of mi_addr (word address).
- AW, 8, BRAM word-address width; depth = 2^AW 32-bit words.
- GAP, 0, idle cycles inserted between consecutive data beats (0 = back-to-back).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- mi_addr  in  ADDR_WIDTH  start word address; only [AW-1:0] used, upper bits ignored.
- mi_len  in  7  burst length minus one (N = mi_len+1 words, 1..128).
- mi_rw  in  1  1 = read, 0 = write.
- mi_valid  in  1  request valid.
- mi_ready  out  1  request accepted when mi_valid & mi_ready.
- mi_wdata  in  32  write data for current beat.
- mi_wack  out  1  pulse: mi_wdata consumed this cycle.
- mi_wlast  out  1  qualifies the final mi_wack of a burst.
- mi_rdata  out  32  read data.
- mi_rstb  out  1  pulse: mi_rdata valid this cycle.
- mi_rlast  out  1  qualifies the final mi_rstb of a burst.

Behaviour:
- Reset (async, rst_n low): state IDLE; mi_ready=0, mi_wack=0, mi_wlast=0, mi_rstb=0, mi_rlast=0, mi_rdata=0; beat and gap counters cleared. mi_ready rises on the first clock edge after rst_n deasserts. BRAM contents are not cleared.
- FSM: IDLE -> WRITE or READ on accept; WRITE/READ -> IDLE after the last beat. mi_ready is registered and is high only in IDLE.
- Accept (cycle T): latch word address A = mi_addr[AW-1:0], beat count N = mi_len+1, and mi_rw. mi_valid outside IDLE is ignored; no queueing.
- Addressing: beat k (0..N-1) uses address (A+k) mod 2^AW. Wrap-around is silent.
- WRITE, GAP=0:
  - mi_wack high on cycles T+1..T+N.
  - On each mi_wack cycle, mi_wdata is written to the current address with all 4 bytes.
  - mi_wlast = mi_wack & last beat.
  - Return to IDLE at T+N+1, with mi_ready high in that cycle.
- READ, GAP=0:
  - BRAM read issued on T+1..T+N (1-cycle synchronous BRAM).
  - mi_rstb with mi_rdata on T+2..T+N+1; mi_rlast with the final mi_rstb.
  - mi_rdata holds its last value when mi_rstb is low.
  - Return to IDLE at T+N+2 (mi_ready high).
- GAP>0: after each beat, the gap counter inserts GAP cycles with mi_wack/read-issue low; latency to the first beat is unchanged.
- Read-after-write: a read accepted after a write burst completes returns the written data, with no hazard.
- mi_wack and mi_rstb are never high in the same cycle.
- Reset mid-burst aborts immediately: outputs go to reset values and any remaining beats are dropped. Words already written stay written.
- N=1: the single beat carries both wack/wlast (or rstb/rlast) together.
- mi_len=127: 128 beats; the counter must not overflow (use an 8-bit remaining count or compare against the latched mi_len).
- Single-port BRAM; pipeline depth 1 register on the read path.

Test Plan:
- Reset, then write addr=0x10, len=3, wdata 0xA0..0xA3 -> mi_wack at T+1..T+4, mi_wlast only at T+4, mi_ready high at T+5. Read back same addr/len -> mi_rstb at T'+2..T'+5, data A0,A1,A2,A3, mi_rlast at T'+5.
- AW=8: write addr=0xFE, len=3 with 1,2,3,4, then read addr=0x00 len=1 -> returns 3,4 (wrap-around). Also check addr 0x1FE aliases to 0xFE.
- len=0 read and write -> single beat with wack+wlast (or rstb+rlast) in the same cycle; len=127 -> exactly 128 strobes, rlast on the 128th.
- GAP=2: write len=2 -> mi_wack at T+1, T+4, T+7. Read len=2 -> mi_rstb at T+2, T+5, T+8.
- mi_valid held high continuously with alternating rw -> each request accepted only when mi_ready=1. No strobe overlap; back-to-back bursts each start one cycle after ready.
- Assert rst_n low at beat 2 of an 8-beat write -> all outputs zero asynchronously. After release, mi_ready=1 on the next edge. Reading words 0..1 returns new data; words beyond return old contents.
